// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one external combinational multiplier.
// A grant cycle latches operands; the following edge captures the product.
module mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 28,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p,
  output logic [2*W-1:0]    dout,
  output logic              dout_valid,
  output logic [IW-1:0]     dout_id,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] id_q;
  logic [IW-1:0] win;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] lo, hi;
  logic          hit_hi;
  logic          go;
  logic [W-1:0]  a_q, b_q;

  // lowest req at/after ptr, else lowest overall (wrap)
  always_comb begin
    lo = '0;
    hi = '0;
    hit_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hi = IW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    win = hit_hi ? hi : lo;
  end

  assign ptr_nxt = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign go = (state_q == IDLE) && (|req);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|req) state_d = CALC;
      CALC: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      dout <= '0;
      dout_id <= '0;
      dout_valid <= 1'b0;
    end else begin
      gnt <= '0;
      dout_valid <= 1'b0;
      if (go) begin
        gnt <= NREQ'(1) << win;
        a_q <= op_a[int'(win)*W +: W];
        b_q <= op_b[int'(win)*W +: W];
        id_q <= win;
        ptr_q <= ptr_nxt;
      end
      if (state_q == CALC) begin
        dout <= mul_p;
        dout_id <= id_q;
        dout_valid <= 1'b1;
      end
    end
  end

  assign mul_a = a_q;
  assign mul_b = b_q;
  assign busy = (state_q == CALC);

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized and directed checks of mul_arbiter
// against a cycle-level reference model.
module tb_mul_arbiter;
  localparam int N = 4;
  localparam int W = 28;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  op_a = '0;
  logic [N*W-1:0]  op_b = '0;
  logic [N-1:0]    gnt;
  logic [W-1:0]    mul_a, mul_b;
  logic [2*W-1:0]  mul_p;
  logic [2*W-1:0]  dout;
  logic            dout_valid;
  logic [IW-1:0]   dout_id;
  logic            busy;

  int total = 0;
  int bad = 0;

  mul_arbiter #(.NREQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .op_a(op_a), .op_b(op_b), .gnt(gnt),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .dout(dout), .dout_valid(dout_valid),
    .dout_id(dout_id), .busy(busy)
  );

  assign mul_p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

  always #5 clk = ~clk;

  // reference model
  logic            m_calc;
  int              m_ptr;
  int              m_id;
  logic [N-1:0]    m_gnt;
  logic [W-1:0]    m_a, m_b;
  logic [2*W-1:0]  m_dout;
  logic [IW-1:0]   m_oid;
  logic            m_valid;
  int              m_win;

  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always_comb m_win = rr_pick(req, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_calc <= 1'b0;
      m_ptr <= 0;
      m_id <= 0;
      m_gnt <= '0;
      m_a <= '0;
      m_b <= '0;
      m_dout <= '0;
      m_oid <= '0;
      m_valid <= 1'b0;
    end else if (!m_calc) begin
      m_valid <= 1'b0;
      if (m_win >= 0) begin
        m_gnt <= N'(1) << m_win;
        m_a <= op_a[m_win*W +: W];
        m_b <= op_b[m_win*W +: W];
        m_id <= m_win;
        m_ptr <= (m_win + 1) % N;
        m_calc <= 1'b1;
      end
    end else begin
      m_dout <= {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
      m_oid <= IW'(m_id);
      m_valid <= 1'b1;
      m_gnt <= '0;
      m_calc <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      total = total + 1;
      if (gnt !== m_gnt || mul_a !== m_a || mul_b !== m_b ||
          busy !== m_calc || dout_valid !== m_valid ||
          dout !== m_dout || dout_id !== m_oid) begin
        bad = bad + 1;
        $display("FAIL model_cmp t=%0t got g=%h a=%h b=%h bz=%b v=%b d=%h id=%0d want g=%h a=%h b=%h bz=%b v=%b d=%h id=%0d",
                 $time, gnt, mul_a, mul_b, busy, dout_valid, dout, dout_id,
                 m_gnt, m_a, m_b, m_calc, m_valid, m_dout, m_oid);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    op_a = '0;
    op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int oh_idx(logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic rr_run(input logic [N-1:0] r, input int n,
                        output int ord[$], output int cyc[$]);
    ord = {};
    cyc = {};
    req = r;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (gnt != '0 && ord.size() < n) begin
        ord.push_back(oh_idx(gnt));
        cyc.push_back(c);
      end
    end
    req = '0;
  endtask

  initial begin
    int ord[$];
    int cyc[$];
    int exp_rr[5];
    int exp_alt[4];

    do_reset();
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mula", 64'(mul_a), 0);
    chk("rst_dout", 64'(dout), 0);

    // single request, slice 1
    step();
    req = 4'b0010;
    op_a[1*W +: W] = 28'd3;
    op_b[1*W +: W] = 28'd5;
    @(negedge clk);
    chk("idle_nognt", 64'(gnt), 0);
    step();
    req = '0;
    chk("g1_gnt", 64'(gnt), 64'h2);
    chk("g1_busy", 64'(busy), 1);
    step();
    chk("g1_valid", 64'(dout_valid), 1);
    chk("g1_dout", 64'(dout), 15);
    chk("g1_id", 64'(dout_id), 1);
    chk("g1_gnt0", 64'(gnt), 0);
    step();
    chk("g1_vclr", 64'(dout_valid), 0);
    chk("g1_hold", 64'(dout), 15);

    // all requesting: 0,1,2,3,0 two cycles apart
    do_reset();
    exp_rr = '{0, 1, 2, 3, 0};
    rr_run(4'b1111, 5, ord, cyc);
    chk("rr_cnt", 64'(ord.size()), 5);
    for (int i = 0; i < ord.size() && i < 5; i++) begin
      chk($sformatf("rr_ord%0d", i), 64'(ord[i]), 64'(exp_rr[i]));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 64'(cyc[i] - cyc[i-1]), 2);
    end

    // 0101 alternates 0,2
    do_reset();
    exp_alt = '{0, 2, 0, 2};
    rr_run(4'b0101, 4, ord, cyc);
    chk("alt_cnt", 64'(ord.size()), 4);
    for (int i = 0; i < ord.size() && i < 4; i++)
      chk($sformatf("alt_ord%0d", i), 64'(ord[i]), 64'(exp_alt[i]));

    // full-width product
    do_reset();
    req = 4'b0001;
    op_a[0 +: W] = '1;
    op_b[0 +: W] = '1;
    step();
    req = '0;
    step();
    chk("max_valid", 64'(dout_valid), 1);
    chk("max_dout", 64'(dout), 64'h00FF_FFFF_E000_0001);

    // reset during CALC aborts
    do_reset();
    req = 4'b0001;
    op_a[0 +: W] = 28'd2;
    op_b[0 +: W] = 28'd7;
    step();
    req = '0;
    chk("ab_gnt", 64'(gnt), 1);
    rst_n = 1'b0;
    #1;
    chk("ab_gnt0", 64'(gnt), 0);
    chk("ab_busy0", 64'(busy), 0);
    chk("ab_mula0", 64'(mul_a), 0);
    chk("ab_v0", 64'(dout_valid), 0);
    chk("ab_dout0", 64'(dout), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ab_novalid", 64'(dout_valid), 0);
    end
    step();
    req = 4'b1000;
    step();
    req = '0;
    chk("ab_gnt3", 64'(gnt), 64'h8);
    step();

    // req pulse only during CALC is ignored
    do_reset();
    req = 4'b0001;
    op_a[0 +: W] = 28'd6;
    op_b[0 +: W] = 28'd7;
    step();
    req = 4'b0100;
    chk("pc_gnt", 64'(gnt), 1);
    step();
    req = '0;
    chk("pc_valid", 64'(dout_valid), 1);
    chk("pc_dout", 64'(dout), 42);
    repeat (3) begin
      step();
      chk("pc_nognt", 64'({gnt, dout_valid}), 0);
    end

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 11) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
          op_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
          op_b[i*W +: W] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
        end
      end
    end
    req = '0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
